// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register fields, hazard-sequencer states and the stage-control bundle.
package cpu_types_pkg;

    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } hazstate_t;

    // Enable/flush for the PC and the four pipeline registers; flush beats enable.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
        logic memwb_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_FREEZE = '0;

    localparam stage_ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0, idex_flush: 1'b1,
        exmem_en: 1'b0, exmem_flush: 1'b1, memwb_en: 1'b0, memwb_flush: 1'b1};

    localparam stage_ctrl_t CTRL_DRAIN = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0, idex_flush: 1'b1,
        exmem_en: 1'b0, exmem_flush: 1'b1, memwb_en: 1'b1, memwb_flush: 1'b0};

    localparam stage_ctrl_t CTRL_REDIRECT = '{
        pc_en: 1'b1, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0, idex_flush: 1'b1,
        exmem_en: 1'b0, exmem_flush: 1'b1, memwb_en: 1'b1, memwb_flush: 1'b0};

    localparam stage_ctrl_t CTRL_LOAD_USE = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0, idex_flush: 1'b1,
        exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1, memwb_flush: 1'b0};

    localparam stage_ctrl_t CTRL_IMISS = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b1, idex_flush: 1'b0,
        exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1, memwb_flush: 1'b0};

    localparam stage_ctrl_t CTRL_ADVANCE = '{
        pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1, idex_flush: 1'b0,
        exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1, memwb_flush: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: IF/ID instruction reads the register a load in ID/EX is about to write.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_memread,
    input  regbits_t ex_wrdest,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_uses_rt,
    output logic     load_use_c
);

    // $zero is never a real dependency.
    assign load_use_c = ex_memread && (ex_wrdest != '0) &&
                        ((ex_wrdest == id_rs) || (id_uses_rt && (ex_wrdest == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: per-stage enable/flush for load-use, redirect, memory waits and halt drain.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  regbits_t         ex_wrdest,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_redirect,
    input  logic             mem_halt,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hazstate_t   state, state_next;
    stage_ctrl_t ctrl_c, advance_c;
    logic        load_use_c;
    logic        dwait_c;
    logic        advancing_c;

    load_use_detect u_load_use (
        .ex_memread (ex_memread),
        .ex_wrdest  (ex_wrdest),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .load_use_c (load_use_c)
    );

    assign dwait_c = (mem_dREN || mem_dWEN) && !dhit;

    // Priorities 2..5 once the data side is not holding the pipe.
    always_comb begin
        advance_c = CTRL_ADVANCE;
        if (mem_redirect) begin
            advance_c = CTRL_REDIRECT;
        end else if (load_use_c) begin
            advance_c = CTRL_LOAD_USE;
        end else if (!ihit) begin
            advance_c = CTRL_IMISS;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        ctrl_c      = CTRL_FREEZE;
        advancing_c = 1'b0;
        case (state)
            RUN: begin
                if (dwait_c) begin
                    state_next = MEMWAIT;
                end else begin
                    ctrl_c      = advance_c;
                    advancing_c = 1'b1;
                    if (mem_halt) begin
                        state_next = DRAIN;
                    end
                end
            end
            MEMWAIT: begin
                // A redirect held behind the access resolves on the dhit cycle.
                if (dhit) begin
                    ctrl_c      = advance_c;
                    advancing_c = 1'b1;
                    state_next  = mem_halt ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                ctrl_c = CTRL_DRAIN;
                if (wb_halt) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                ctrl_c = CTRL_FREEZE;
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (RST) begin
            ctrl_c      = CTRL_RESET;
            advancing_c = 1'b0;
            state_next  = RUN;
        end
    end

    assign pc_en       = ctrl_c.pc_en;
    assign ifid_en     = ctrl_c.ifid_en;
    assign ifid_flush  = ctrl_c.ifid_flush;
    assign idex_en     = ctrl_c.idex_en;
    assign idex_flush  = ctrl_c.idex_flush;
    assign exmem_en    = ctrl_c.exmem_en;
    assign exmem_flush = ctrl_c.exmem_flush;
    assign memwb_en    = ctrl_c.memwb_en;
    assign memwb_flush = ctrl_c.memwb_flush;
    assign halt        = (state == HALTED) && !RST;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cyc_q, stall_q, flush_q;
    logic             stall_c, redirect_c;

    assign stall_c    = ((state == RUN) || (state == MEMWAIT)) && !ctrl_c.pc_en;
    assign redirect_c = advancing_c && mem_redirect;

    // Saturating perf counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((state != HALTED) && (cyc_q != CNT_MAX)) begin
                cyc_q <= cyc_q + CNT_W'(1);
            end
            if (stall_c && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (redirect_c && (flush_q != CNT_MAX)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign cyc_cnt   = cyc_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign cyc_cnt   = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: cycle model compared every cycle plus hand-computed checks.
module tb_pipeline_hazard_ctrl;

    localparam int TB_CNT_W = 4;
    localparam int CMAX     = (1 << TB_CNT_W) - 1;
    localparam int HOLD = 0, LOAD = 1, BUBBLE = 2;
    localparam int M_RUN = 0, M_MEMWAIT = 1, M_DRAIN = 2, M_HALTED = 3;

    logic CLK = 1'b0;
    logic RST;
    logic ihit, dhit, id_uses_rt, ex_memread, mem_dREN, mem_dWEN, mem_redirect, mem_halt, wb_halt;
    logic [4:0] id_rs, id_rt, ex_wrdest;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush;
    logic memwb_en, memwb_flush, halt;
    logic [TB_CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic check_en = 1'b0;

    pipeline_hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_wrdest(ex_wrdest),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_redirect(mem_redirect),
        .mem_halt(mem_halt), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush), .halt(halt),
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int stage_act(input logic en, input logic flush);
        if (flush === 1'b1) return BUBBLE;
        if (en === 1'b1) return LOAD;
        if (en === 1'b0) return HOLD;
        return -1;
    endfunction

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_wrdest = '0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        mem_redirect = 1'b0; mem_halt = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Behavioural model: mode of the sequencer and the counter values it should hold.
    int mode = M_RUN;
    int m_cyc = 0, m_stall = 0, m_flush = 0;
    int e_pc, e_halt;
    int e_act [4];
    logic lu, dw, adv;

    always @(negedge CLK) begin
        if (check_en) begin
            lu  = ex_memread && (ex_wrdest != 0) &&
                  ((ex_wrdest == id_rs) || (id_uses_rt && (ex_wrdest == id_rt)));
            dw  = (mem_dREN || mem_dWEN) && !dhit;
            adv = !RST && (((mode == M_RUN) && !dw) || ((mode == M_MEMWAIT) && dhit));
            e_halt = (!RST && mode == M_HALTED) ? 1 : 0;
            if (RST) begin
                e_pc = 0; e_act = '{BUBBLE, BUBBLE, BUBBLE, BUBBLE};
            end else if (mode == M_DRAIN) begin
                e_pc = 0; e_act = '{BUBBLE, BUBBLE, BUBBLE, LOAD};
            end else if (!adv) begin
                e_pc = 0; e_act = '{HOLD, HOLD, HOLD, HOLD};
            end else if (mem_redirect) begin
                e_pc = 1; e_act = '{BUBBLE, BUBBLE, BUBBLE, LOAD};
            end else if (lu) begin
                e_pc = 0; e_act = '{HOLD, BUBBLE, LOAD, LOAD};
            end else if (!ihit) begin
                e_pc = 0; e_act = '{BUBBLE, LOAD, LOAD, LOAD};
            end else begin
                e_pc = 1; e_act = '{LOAD, LOAD, LOAD, LOAD};
            end

            chk("m_pc_en", 32'(pc_en), 32'(e_pc));
            chk("m_ifid", 32'(stage_act(ifid_en, ifid_flush)), 32'(e_act[0]));
            chk("m_idex", 32'(stage_act(idex_en, idex_flush)), 32'(e_act[1]));
            chk("m_exmem", 32'(stage_act(exmem_en, exmem_flush)), 32'(e_act[2]));
            chk("m_memwb", 32'(stage_act(memwb_en, memwb_flush)), 32'(e_act[3]));
            chk("m_halt", 32'(halt), 32'(e_halt));
            chk("m_cyc_cnt", 32'(cyc_cnt), 32'(m_cyc));
            chk("m_stall_cnt", 32'(stall_cnt), 32'(m_stall));
            chk("m_flush_cnt", 32'(flush_cnt), 32'(m_flush));

            if (RST) begin
                mode = M_RUN; m_cyc = 0; m_stall = 0; m_flush = 0;
            end else begin
`ifdef PIPE_PERF_CNT_EN
                if (mode != M_HALTED && m_cyc < CMAX) m_cyc++;
                if ((mode == M_RUN || mode == M_MEMWAIT) && e_pc == 0 && m_stall < CMAX) m_stall++;
                if (adv && mem_redirect && m_flush < CMAX) m_flush++;
`endif
                case (mode)
                    M_RUN:     mode = dw ? M_MEMWAIT : (mem_halt ? M_DRAIN : M_RUN);
                    M_MEMWAIT: mode = dhit ? (mem_halt ? M_DRAIN : M_RUN) : M_MEMWAIT;
                    M_DRAIN:   mode = wb_halt ? M_HALTED : M_DRAIN;
                    default:   mode = M_HALTED;
                endcase
            end
        end
    end

    initial begin
        idle();
        RST = 1'b1;
        tick();
        check_en = 1'b1;
        #1;
        chk("rst_pc_en", 32'(pc_en), 0);
        chk("rst_ifid_en", 32'(ifid_en), 0);
        chk("rst_memwb_flush", 32'(memwb_flush), 1);
        chk("rst_halt", 32'(halt), 0);
        tick();
        RST = 1'b0; #1;
        chk("run_pc_en", 32'(pc_en), 1);
        chk("run_memwb_en", 32'(memwb_en), 1);

        // lw $2 ; add $3,$2,$4
        tick();
        ex_memread = 1'b1; ex_wrdest = 5'd2; id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1'b1; #1;
        chk("lu_pc_en", 32'(pc_en), 0);
        chk("lu_idex_flush", 32'(idex_flush), 1);
        chk("lu_ifid_en", 32'(ifid_en), 0);
        chk("lu_exmem_en", 32'(exmem_en), 1);
        tick();
        ex_memread = 1'b0; #1;
        chk("lu_after_pc_en", 32'(pc_en), 1);
        chk("lu_after_idex_flush", 32'(idex_flush), 0);
        tick();
        ex_memread = 1'b1; ex_wrdest = 5'd0; id_rs = 5'd0; #1;
        chk("lu_r0_pc_en", 32'(pc_en), 1);
        tick();
        ex_wrdest = 5'd4; id_rs = 5'd1; id_rt = 5'd4; id_uses_rt = 1'b1; #1;
        chk("lu_rt_pc_en", 32'(pc_en), 0);
        tick();
        id_uses_rt = 1'b0; #1;
        chk("lu_rt_unused_pc_en", 32'(pc_en), 1);

        // sw with dhit low for 3 cycles
        tick();
        idle(); mem_dWEN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            chk("sw_wait_pc_en", 32'(pc_en), 0);
            chk("sw_wait_ifid_en", 32'(ifid_en), 0);
            chk("sw_wait_memwb_en", 32'(memwb_en), 0);
            chk("sw_wait_exmem_flush", 32'(exmem_flush), 0);
        end
        tick();
        dhit = 1'b1; #1;
        chk("sw_hit_pc_en", 32'(pc_en), 1);
        chk("sw_hit_ifid_en", 32'(ifid_en), 1);
        chk("sw_hit_memwb_en", 32'(memwb_en), 1);
        tick();
        idle(); #1;
        chk("sw_back_run_pc_en", 32'(pc_en), 1);

        // taken beq
        tick();
        mem_redirect = 1'b1; #1;
        chk("br_pc_en", 32'(pc_en), 1);
        chk("br_ifid_flush", 32'(ifid_flush), 1);
        chk("br_idex_flush", 32'(idex_flush), 1);
        chk("br_exmem_flush", 32'(exmem_flush), 1);
        chk("br_memwb_en", 32'(memwb_en), 1);
        tick();
        mem_redirect = 1'b0; #1;
        chk("br_after_ifid_flush", 32'(ifid_flush), 0);

        // redirect pending behind a data wait
        tick();
        mem_dREN = 1'b1; dhit = 1'b0; mem_redirect = 1'b1; #1;
        chk("mw_br_exmem_flush0", 32'(exmem_flush), 0);
        chk("mw_br_pc_en0", 32'(pc_en), 0);
        tick(); #1;
        chk("mw_br_exmem_flush1", 32'(exmem_flush), 0);
        tick();
        dhit = 1'b1; #1;
        chk("mw_br_hit_ifid_flush", 32'(ifid_flush), 1);
        chk("mw_br_hit_exmem_flush", 32'(exmem_flush), 1);
        chk("mw_br_hit_pc_en", 32'(pc_en), 1);
        tick();
        idle(); #1;
        chk("mw_br_after_pc_en", 32'(pc_en), 1);
        chk("mw_br_after_exmem_flush", 32'(exmem_flush), 0);

        // instruction fetch miss
        tick();
        ihit = 1'b0; #1;
        chk("imiss_pc_en", 32'(pc_en), 0);
        chk("imiss_ifid_flush", 32'(ifid_flush), 1);
        chk("imiss_idex_en", 32'(idex_en), 1);

        // halt drain and sticky halt
        tick();
        idle(); mem_halt = 1'b1; #1;
        chk("hlt_mem_pc_en", 32'(pc_en), 1);
        chk("hlt_mem_halt", 32'(halt), 0);
        tick();
        mem_halt = 1'b0; wb_halt = 1'b1; #1;
        chk("drain_pc_en", 32'(pc_en), 0);
        chk("drain_idex_flush", 32'(idex_flush), 1);
        chk("drain_memwb_en", 32'(memwb_en), 1);
        chk("drain_halt", 32'(halt), 0);
        tick();
        wb_halt = 1'b0; #1;
        chk("halted_halt", 32'(halt), 1);
        chk("halted_pc_en", 32'(pc_en), 0);
        chk("halted_memwb_en", 32'(memwb_en), 0);
        repeat (4) begin
            tick();
            ihit = ~ihit; #1;
            chk("halted_sticky", 32'(halt), 1);
            chk("halted_ifid_en", 32'(ifid_en), 0);
        end

        // reset out of HALTED
        tick();
        idle(); RST = 1'b1; #1;
        chk("hrst_halt", 32'(halt), 0);
        tick();
        RST = 1'b0; #1;
        chk("hrst_run_pc_en", 32'(pc_en), 1);

        // halt and redirect together, then reset mid-drain
        tick();
        mem_halt = 1'b1; mem_redirect = 1'b1; #1;
        chk("hb_exmem_flush", 32'(exmem_flush), 1);
        tick();
        idle(); #1;
        chk("hb_drain_pc_en", 32'(pc_en), 0);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; #1;
        chk("drst_pc_en", 32'(pc_en), 1);

        // reset mid-MEMWAIT abandons the access
        tick();
        mem_dREN = 1'b1; dhit = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        idle(); RST = 1'b0; #1;
        chk("mrst_pc_en0", 32'(pc_en), 1);
        tick(); #1;
        chk("mrst_pc_en1", 32'(pc_en), 1);

        // 20 stall cycles saturate a 4-bit counter
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; ihit = 1'b0;
        repeat (20) tick();
        #1;
`ifdef PIPE_PERF_CNT_EN
        chk("sat_stall_cnt", 32'(stall_cnt), 15);
        chk("sat_cyc_cnt", 32'(cyc_cnt), 15);
`else
        chk("nocnt_stall_cnt", 32'(stall_cnt), 0);
        chk("nocnt_cyc_cnt", 32'(cyc_cnt), 0);
`endif
        chk("sat_flush_cnt", 32'(flush_cnt), 0);
        tick();
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
